// File: rtl/ecc_decoder_pipe_if.sv
// Bus bundle for the SEC-DED decoder pipeline: input word handshake,
// corrected output handshake and the error-statistics side band.
interface ecc_decoder_pipe_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      data_in;
    logic [4:0]       parity_in;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      data_out;
    logic             sec_err;
    logic             ded_err;
    logic [3:0]       syndrome_out;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;
    logic             ded_sticky;
    logic             cnt_clr;

    modport master (
        output in_valid, data_in, parity_in, out_ready, cnt_clr,
        input  in_ready, out_valid, data_out, sec_err, ded_err,
               syndrome_out, sec_cnt, ded_cnt, ded_sticky
    );

    modport slave (
        input  in_valid, data_in, parity_in, out_ready, cnt_clr,
        output in_ready, out_valid, data_out, sec_err, ded_err,
               syndrome_out, sec_cnt, ded_cnt, ded_sticky
    );
endinterface

// File: rtl/ecc_decoder_pipe.sv
// Two-stage Hamming(16,11) SEC-DED checker: stage 1 captures the syndrome,
// stage 2 corrects/classifies into the output registers and updates statistics.
module ecc_decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_decoder_pipe_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1Full;
    logic [10:0]      r_s1Data;
    logic [3:0]       r_s1Syn;
    logic             r_s1Ovr;

    logic             r_s2Full;
    logic [10:0]      r_dataOut;
    logic             r_secErr;
    logic             r_dedErr;
    logic [3:0]       r_synOut;

    logic [CNT_W-1:0] r_secCnt;
    logic [CNT_W-1:0] r_dedCnt;
    logic             r_dedSticky;

    logic [3:0]       w_check;
    logic [3:0]       w_syn;
    logic             w_ovr;
    logic             w_s2Drain;
    logic             w_s2Load;
    logic             w_s1Advance;
    logic             w_inReady;
    logic             w_inFire;
    logic [10:0]      w_corrMask;
    logic             w_isSec;
    logic             w_isDed;
    logic [10:0]      w_corrData;

    always_comb begin
        w_check[0] = bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3] ^ bus.data_in[4]
                   ^ bus.data_in[6] ^ bus.data_in[8] ^ bus.data_in[10];
        w_check[1] = bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3] ^ bus.data_in[5]
                   ^ bus.data_in[6] ^ bus.data_in[9] ^ bus.data_in[10];
        w_check[2] = bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3] ^ bus.data_in[7]
                   ^ bus.data_in[8] ^ bus.data_in[9] ^ bus.data_in[10];
        w_check[3] = ^bus.data_in[10:4];
    end

    assign w_syn = w_check ^ bus.parity_in[3:0];
    assign w_ovr = ^{bus.data_in, bus.parity_in};

    // Each stage refills when empty or when its word leaves in the same cycle.
    assign w_s2Drain   = r_s2Full & bus.out_ready;
    assign w_s2Load    = !r_s2Full | w_s2Drain;
    assign w_s1Advance = r_s1Full & w_s2Load;
    assign w_inReady   = !r_s1Full | w_s1Advance;
    assign w_inFire    = bus.in_valid & w_inReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Full <= 1'b0;
            r_s1Data <= '0;
            r_s1Syn  <= '0;
            r_s1Ovr  <= 1'b0;
        end else if (w_inFire) begin
            r_s1Full <= 1'b1;
            r_s1Data <= bus.data_in;
            r_s1Syn  <= w_syn;
            r_s1Ovr  <= w_ovr;
        end else if (w_s1Advance) begin
            r_s1Full <= 1'b0;
        end
    end

    // Map a syndrome naming a data position onto its data bit; parity positions map to nothing.
    always_comb begin
        w_corrMask = '0;
        case (r_s1Syn)
            4'd3:    w_corrMask[0]  = 1'b1;
            4'd5:    w_corrMask[1]  = 1'b1;
            4'd6:    w_corrMask[2]  = 1'b1;
            4'd7:    w_corrMask[3]  = 1'b1;
            4'd9:    w_corrMask[4]  = 1'b1;
            4'd10:   w_corrMask[5]  = 1'b1;
            4'd11:   w_corrMask[6]  = 1'b1;
            4'd12:   w_corrMask[7]  = 1'b1;
            4'd13:   w_corrMask[8]  = 1'b1;
            4'd14:   w_corrMask[9]  = 1'b1;
            4'd15:   w_corrMask[10] = 1'b1;
            default: w_corrMask = '0;
        endcase
    end

    assign w_isSec    = r_s1Ovr;
    assign w_isDed    = !r_s1Ovr & (r_s1Syn != 4'd0);
    assign w_corrData = w_isSec ? (r_s1Data ^ w_corrMask) : r_s1Data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Full  <= 1'b0;
            r_dataOut <= '0;
            r_secErr  <= 1'b0;
            r_dedErr  <= 1'b0;
            r_synOut  <= '0;
        end else if (w_s1Advance) begin
            r_s2Full  <= 1'b1;
            r_dataOut <= w_corrData;
            r_secErr  <= w_isSec;
            r_dedErr  <= w_isDed;
            r_synOut  <= r_s1Syn;
        end else if (w_s2Drain) begin
            r_s2Full  <= 1'b0;
        end
    end

    // Statistics only move on an output handshake; a clear wins and swallows that event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_secCnt    <= '0;
            r_dedCnt    <= '0;
            r_dedSticky <= 1'b0;
        end else if (bus.cnt_clr) begin
            r_secCnt    <= '0;
            r_dedCnt    <= '0;
            r_dedSticky <= 1'b0;
        end else if (w_s2Drain) begin
            if (r_secErr && (r_secCnt != CNT_MAX)) begin
                r_secCnt <= r_secCnt + 1'b1;
            end
            if (r_dedErr) begin
                r_dedSticky <= 1'b1;
                if (r_dedCnt != CNT_MAX) begin
                    r_dedCnt <= r_dedCnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = w_inReady;
    assign bus.out_valid    = r_s2Full;
    assign bus.data_out     = r_dataOut;
    assign bus.sec_err      = r_secErr;
    assign bus.ded_err      = r_dedErr;
    assign bus.syndrome_out = r_synOut;
    assign bus.sec_cnt      = r_secCnt;
    assign bus.ded_cnt      = r_dedCnt;
    assign bus.ded_sticky   = r_dedSticky;
endmodule

// File: tb/tb_ecc_decoder_pipe.sv
// Directed bench for ecc_decoder_pipe: a vector table of hand-encoded words
// plus sequences for backpressure, clear, reset and counter saturation.
module tb_ecc_decoder_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ecc_decoder_pipe_if #(.CNT_W(8)) ifMain ();
    ecc_decoder_pipe_if #(.CNT_W(2)) ifSat ();

    ecc_decoder_pipe #(.CNT_W(8)) dutMain (.clk(clk), .rst(rst), .bus(ifMain));
    ecc_decoder_pipe #(.CNT_W(2)) dutSat  (.clk(clk), .rst(rst), .bus(ifSat));

    typedef struct packed {
        logic [10:0] data;
        logic [4:0]  parity;
        logic [10:0] expData;
        logic [3:0]  expSyn;
        logic        expSec;
        logic        expDed;
    } vec_t;

    vec_t        vecs [12];
    logic [10:0] bpData [4];
    logic [4:0]  bpParity [4];
    int          nTests = 0;
    int          nFail  = 0;
    int          expSecCnt = 0;
    int          expDedCnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [10:0] d, input logic [4:0] p,
                                 input logic rdy, input logic clr);
        ifMain.in_valid  = v;
        ifMain.data_in   = d;
        ifMain.parity_in = p;
        ifMain.out_ready = rdy;
        ifMain.cnt_clr   = clr;
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Hand-encoded vectors: clean word 5A5 carries parity 0x11, 7FF carries 0x1F.
        vecs[0]  = '{11'h5A5, 5'h11, 11'h5A5, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{11'h5E5, 5'h11, 11'h5A5, 4'hB, 1'b1, 1'b0};
        vecs[2]  = '{11'h5A5, 5'h01, 11'h5A5, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{11'h5A5, 5'h15, 11'h5A5, 4'h4, 1'b1, 1'b0};
        vecs[4]  = '{11'h5E4, 5'h11, 11'h5E4, 4'h8, 1'b0, 1'b1};
        vecs[5]  = '{11'h1A5, 5'h11, 11'h5A5, 4'hF, 1'b1, 1'b0};
        vecs[6]  = '{11'h5A4, 5'h11, 11'h5A5, 4'h3, 1'b1, 1'b0};
        vecs[7]  = '{11'h000, 5'h00, 11'h000, 4'h0, 1'b0, 1'b0};
        vecs[8]  = '{11'h7FF, 5'h1F, 11'h7FF, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{11'h7EF, 5'h1F, 11'h7FF, 4'h9, 1'b1, 1'b0};
        vecs[10] = '{11'h000, 5'h03, 11'h000, 4'h3, 1'b0, 1'b1};
        vecs[11] = '{11'h000, 5'h01, 11'h000, 4'h1, 1'b1, 1'b0};
        bpData[0] = 11'h5A5; bpParity[0] = 5'h11;
        bpData[1] = 11'h001; bpParity[1] = 5'h13;
        bpData[2] = 11'h7FF; bpParity[2] = 5'h1F;
        bpData[3] = 11'h000; bpParity[3] = 5'h00;

        rst = 1'b1;
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b0, 1'b0);
        ifSat.in_valid  = 1'b0;
        ifSat.data_in   = '0;
        ifSat.parity_in = '0;
        ifSat.out_ready = 1'b0;
        ifSat.cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", 32'(ifMain.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset in_ready",  32'(ifMain.in_ready),   32'd1);
        checkOutput("post-reset out_valid", 32'(ifMain.out_valid),  32'd0);
        checkOutput("post-reset data_out",  32'(ifMain.data_out),   32'd0);
        checkOutput("post-reset sec_cnt",   32'(ifMain.sec_cnt),    32'd0);
        checkOutput("post-reset ded_cnt",   32'(ifMain.ded_cnt),    32'd0);
        checkOutput("post-reset sticky",    32'(ifMain.ded_sticky), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].data, vecs[i].parity, 1'b1, 1'b0);
            #1 checkOutput($sformatf("v%0d in_ready", i), 32'(ifMain.in_ready), 32'd1);
            @(negedge clk);
            applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b0);
            checkOutput($sformatf("v%0d latency1 out_valid", i), 32'(ifMain.out_valid), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d out_valid", i), 32'(ifMain.out_valid), 32'd1);
            checkOutput($sformatf("v%0d data_out", i), 32'(ifMain.data_out), 32'(vecs[i].expData));
            checkOutput($sformatf("v%0d syndrome", i), 32'(ifMain.syndrome_out), 32'(vecs[i].expSyn));
            checkOutput($sformatf("v%0d sec_err", i), 32'(ifMain.sec_err), 32'(vecs[i].expSec));
            checkOutput($sformatf("v%0d ded_err", i), 32'(ifMain.ded_err), 32'(vecs[i].expDed));
            @(negedge clk);
            if (vecs[i].expSec) expSecCnt++;
            if (vecs[i].expDed) expDedCnt++;
            checkOutput($sformatf("v%0d sec_cnt", i), 32'(ifMain.sec_cnt), 32'(expSecCnt));
            checkOutput($sformatf("v%0d ded_cnt", i), 32'(ifMain.ded_cnt), 32'(expDedCnt));
            checkOutput($sformatf("v%0d sticky", i), 32'(ifMain.ded_sticky), 32'(expDedCnt > 0));
        end

        // Backpressure: consumer stalls for the first four cycles.
        begin
            int tx = 0;
            int rx = 0;
            for (int c = 0; c < 40 && rx < 4; c++) begin
                logic fire;
                if (tx < 4) applyStimulus(1'b1, bpData[tx], bpParity[tx], (c >= 4), 1'b0);
                else        applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b0);
                #1;
                fire = ifMain.in_valid & ifMain.in_ready;
                if (c == 2 || c == 3) begin
                    checkOutput($sformatf("bp c%0d in_ready", c), 32'(ifMain.in_ready), 32'd0);
                    checkOutput($sformatf("bp c%0d accepted", c), 32'(tx), 32'd2);
                    checkOutput($sformatf("bp c%0d held data", c), 32'(ifMain.data_out), 32'(bpData[0]));
                    checkOutput($sformatf("bp c%0d out_valid", c), 32'(ifMain.out_valid), 32'd1);
                end
                if (ifMain.out_valid && ifMain.out_ready) begin
                    checkOutput($sformatf("bp word%0d", rx), 32'(ifMain.data_out), 32'(bpData[rx]));
                    rx++;
                end
                if (fire) tx++;
                @(negedge clk);
            end
            checkOutput("bp words sent", 32'(tx), 32'd4);
            checkOutput("bp words received", 32'(rx), 32'd4);
            checkOutput("bp no duplicate", 32'(ifMain.out_valid), 32'd0);
        end

        // Clear coincident with a double-error handshake.
        applyStimulus(1'b1, 11'h5E4, 5'h11, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (ifMain.out_valid) break;
            @(negedge clk);
        end
        checkOutput("clr word arrives", 32'(ifMain.out_valid), 32'd1);
        checkOutput("clr word ded_err", 32'(ifMain.ded_err), 32'd1);
        @(negedge clk);
        checkOutput("stalled ded_cnt", 32'(ifMain.ded_cnt), 32'(expDedCnt));
        checkOutput("stalled sec_cnt", 32'(ifMain.sec_cnt), 32'(expSecCnt));
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b0);
        checkOutput("clr ded_cnt", 32'(ifMain.ded_cnt), 32'd0);
        checkOutput("clr sec_cnt", 32'(ifMain.sec_cnt), 32'd0);
        checkOutput("clr sticky", 32'(ifMain.ded_sticky), 32'd0);
        checkOutput("clr drained", 32'(ifMain.out_valid), 32'd0);

        // Reset with both stages full after a counted single error.
        applyStimulus(1'b1, 11'h5E5, 5'h11, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("pre-reset sec_cnt", 32'(ifMain.sec_cnt), 32'd1);
        applyStimulus(1'b1, 11'h5A5, 5'h11, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 11'h000, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b0, 1'b0);
        #1;
        checkOutput("full out_valid", 32'(ifMain.out_valid), 32'd1);
        checkOutput("full in_ready", 32'(ifMain.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid-reset out_valid", 32'(ifMain.out_valid), 32'd0);
        checkOutput("mid-reset sec_cnt", 32'(ifMain.sec_cnt), 32'd0);
        checkOutput("mid-reset data_out", 32'(ifMain.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 11'h0, 5'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("after reset out_valid", 32'(ifMain.out_valid), 32'd0);
        checkOutput("after reset in_ready", 32'(ifMain.in_ready), 32'd1);

        // Saturation on the 2-bit counter instance: five single errors.
        begin
            int tx = 0;
            int rx = 0;
            for (int c = 0; c < 40 && rx < 5; c++) begin
                logic fire;
                ifSat.in_valid  = (tx < 5);
                ifSat.data_in   = 11'h5E5;
                ifSat.parity_in = 5'h11;
                ifSat.out_ready = 1'b1;
                #1;
                fire = ifSat.in_valid & ifSat.in_ready;
                if (ifSat.out_valid) begin
                    checkOutput($sformatf("sat word%0d data", rx), 32'(ifSat.data_out), 32'h5A5);
                    rx++;
                end
                if (fire) tx++;
                @(negedge clk);
            end
            ifSat.in_valid = 1'b0;
            @(negedge clk);
            checkOutput("sat words received", 32'(rx), 32'd5);
            checkOutput("sat sec_cnt", 32'(ifSat.sec_cnt), 32'd3);
            checkOutput("sat ded_cnt", 32'(ifSat.ded_cnt), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
